// File: rtl/ascii_text_buffer.sv
// Serial ASCII byte stream to packed character array for the text overlay.
// Tracks a linear cursor, handles CR/LF/BS/FF and scrolls one row on overflow.
module ascii_text_buffer #(
    parameter int COLUMNS  = 16,
    parameter int NUM_CHAR = 300
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_byte,
    input  logic                          i_byte_dv,
    output logic                          o_ready,
    output logic [NUM_CHAR-1:0][7:0]      o_characters,
    output logic [$clog2(NUM_CHAR)-1:0]   o_cursor,
    output logic                          o_update
);
    localparam int CW = $clog2(NUM_CHAR);
    localparam int XW = CW + 1;
    localparam logic [XW-1:0] COLS_X = XW'(COLUMNS);
    localparam logic [XW-1:0] NC_X   = XW'(NUM_CHAR);
    localparam logic [7:0]    SPACE  = 8'h20;

    typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} state_t;

    state_t                   state, state_nxt;
    logic [NUM_CHAR-1:0][7:0] cells;  // cells[p] holds linear cell p
    logic [CW-1:0]            cursor, cursor_nxt;
    logic [CW-1:0]            pend, pend_nxt;
    logic [CW-1:0]            clr_idx, clr_idx_nxt;
    logic                     wr_en, do_scroll, upd_nxt;
    logic [CW-1:0]            wr_addr;
    logic [7:0]               wr_data;

    // Cursor arithmetic one bit wider so p+1 and the next row start never wrap.
    logic [XW-1:0] p_x, p_inc, col, row_base, q_next;

    assign p_x      = XW'(cursor);
    assign p_inc    = p_x + XW'(1);
    assign col      = p_x % COLS_X;
    assign row_base = p_x - col;
    assign q_next   = row_base + COLS_X;

    always_comb begin
        state_nxt   = state;
        cursor_nxt  = cursor;
        pend_nxt    = pend;
        clr_idx_nxt = clr_idx;
        wr_en       = 1'b0;
        wr_addr     = cursor;
        wr_data     = SPACE;
        do_scroll   = 1'b0;
        upd_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (i_byte_dv) begin
                    if (i_byte >= 8'h20 && i_byte <= 8'h7E) begin
                        wr_en   = 1'b1;
                        wr_data = i_byte;
                        upd_nxt = 1'b1;
                        if (p_inc < NC_X) begin
                            cursor_nxt = CW'(p_inc);
                        end else begin
                            state_nxt = SCROLL;
                            pend_nxt  = CW'(p_inc - COLS_X);
                        end
                    end else begin
                        case (i_byte)
                            8'h0D: cursor_nxt = CW'(row_base);
                            8'h0A: begin
                                if (q_next < NC_X) begin
                                    cursor_nxt = CW'(q_next);
                                end else begin
                                    state_nxt = SCROLL;
                                    pend_nxt  = CW'(q_next - COLS_X);
                                end
                            end
                            8'h08: begin
                                if (col != '0) begin
                                    cursor_nxt = cursor - CW'(1);
                                    wr_en      = 1'b1;
                                    wr_addr    = cursor - CW'(1);
                                    upd_nxt    = 1'b1;
                                end
                            end
                            // o_update is raised from the first clear cycle onward
                            8'h0C: begin
                                state_nxt   = CLEAR;
                                clr_idx_nxt = '0;
                                upd_nxt     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            SCROLL: begin
                do_scroll  = 1'b1;
                upd_nxt    = 1'b1;
                cursor_nxt = pend;
                state_nxt  = IDLE;
            end
            CLEAR: begin
                wr_en       = 1'b1;
                wr_addr     = clr_idx;
                upd_nxt     = 1'b1;
                clr_idx_nxt = clr_idx + CW'(1);
                if (clr_idx == CW'(NUM_CHAR - 1)) begin
                    state_nxt  = IDLE;
                    cursor_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cursor   <= '0;
            pend     <= '0;
            clr_idx  <= '0;
            o_update <= 1'b0;
        end else begin
            state    <= state_nxt;
            cursor   <= cursor_nxt;
            pend     <= pend_nxt;
            clr_idx  <= clr_idx_nxt;
            o_update <= upd_nxt;
        end
    end

    // Scroll is a linear shift by COLUMNS cells, so the blank tail may span two rows.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cells <= {NUM_CHAR{SPACE}};
        end else if (do_scroll) begin
            for (int j = 0; j < NUM_CHAR - COLUMNS; j++)
                cells[j] <= cells[j+COLUMNS];
            for (int j = NUM_CHAR - COLUMNS; j < NUM_CHAR; j++)
                cells[j] <= SPACE;
        end else if (wr_en) begin
            cells[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_CHAR; p++)
            o_characters[NUM_CHAR-1-p] = cells[p];
    end

    assign o_ready  = (state == IDLE);
    assign o_cursor = cursor;

endmodule

// File: tb/tb_ascii_text_buffer.sv
// Bench for ascii_text_buffer: directed bytes, a cell-array model and per-cycle compare.
module tb_ascii_text_buffer;
    localparam int C = 16;
    localparam int N = 300;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            dv  = 1'b0;
    logic [7:0]      byt = 8'h00;
    logic            ready, upd;
    logic [N-1:0][7:0] chars;
    logic [8:0]      cur;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ascii_text_buffer #(.COLUMNS(C), .NUM_CHAR(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_byte(byt), .i_byte_dv(dv),
        .o_ready(ready), .o_characters(chars), .o_cursor(cur), .o_update(upd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: text grid as a plain array; busy cycles stand in for scroll/clear.
    logic [7:0] m_cells [N];
    int  m_cur = 0, m_busy = 0, m_pend = 0;
    bit  m_scroll = 0, m_upd = 0, m_live = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < N; p++) m_cells[p] = 8'h20;
            m_cur = 0; m_busy = 0; m_upd = 0; m_live = 1;
        end else if (m_live) begin
            m_upd = 0;
            if (m_busy > 0) begin
                m_busy--;
                m_upd = 1;
                if (m_busy == 0) begin
                    if (m_scroll) begin
                        for (int j = 0; j < N; j++)
                            m_cells[j] = (j + C < N) ? m_cells[j+C] : 8'h20;
                        m_cur = m_pend;
                    end else begin
                        for (int j = 0; j < N; j++) m_cells[j] = 8'h20;
                        m_cur = 0;
                    end
                end
            end else if (dv) begin
                if (byt >= 8'h20 && byt <= 8'h7E) begin
                    m_cells[m_cur] = byt;
                    m_upd = 1;
                    if (m_cur + 1 < N) m_cur = m_cur + 1;
                    else begin m_busy = 1; m_scroll = 1; m_pend = m_cur + 1 - C; end
                end else if (byt == 8'h0D) begin
                    m_cur = (m_cur / C) * C;
                end else if (byt == 8'h0A) begin
                    if ((m_cur / C + 1) * C < N) m_cur = (m_cur / C + 1) * C;
                    else begin m_busy = 1; m_scroll = 1; m_pend = (m_cur / C) * C; end
                end else if (byt == 8'h08) begin
                    if (m_cur % C != 0) begin
                        m_cur = m_cur - 1;
                        m_cells[m_cur] = 8'h20;
                        m_upd = 1;
                    end
                end else if (byt == 8'h0C) begin
                    m_busy = N; m_scroll = 0; m_upd = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            int bad;
            bad = 0;
            chk("ready", 32'(ready), 32'(m_busy == 0));
            chk("update", 32'(upd), 32'(m_upd));
            if (m_busy == 0) begin
                chk("cursor", 32'(cur), 32'(m_cur));
                for (int p = N - 1; p >= 0; p--)
                    if (chars[N-1-p] !== m_cells[p]) bad = p;
                chk($sformatf("cell%0d", bad), 32'(chars[N-1-bad]), 32'(m_cells[bad]));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!ready && n < 1000) begin n++; @(negedge clk); end
        if (n == 1000) chk("ready_wait", 32'(ready), 32'd1);
        byt = b; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit all_upd;
        // reset with a byte presented simultaneously: byte dropped
        byt = 8'h5A; dv = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; dv = 1'b0;
        chk("rst_cursor", 32'(cur), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_update", 32'(upd), 32'd0);
        chk("rst_cell0", 32'(chars[299]), 32'h20);

        send(8'h48);
        chk("H_update", 32'(upd), 32'd1);
        chk("H_cell0", 32'(chars[299]), 32'h48);
        send(8'h69);
        chk("i_cell1", 32'(chars[298]), 32'h69);
        chk("i_cursor", 32'(cur), 32'd2);
        @(negedge clk);
        chk("idle_update", 32'(upd), 32'd0);

        // CR/LF from cursor 20
        send(8'h0A);
        for (int i = 0; i < 4; i++) send(8'(8'h61 + i));
        chk("pre_cr_cursor", 32'(cur), 32'd20);
        send(8'h0D);
        chk("cr_cursor", 32'(cur), 32'd16);
        chk("cr_update", 32'(upd), 32'd0);
        send(8'h0A);
        chk("lf_cursor", 32'(cur), 32'd32);
        chk("lf_update", 32'(upd), 32'd0);

        // BS at column 0, then mid-row
        do_reset();
        send(8'h0A);
        send(8'h08);
        chk("bs_col0_cursor", 32'(cur), 32'd16);
        chk("bs_col0_update", 32'(upd), 32'd0);
        send(8'h78); send(8'h79);
        send(8'h08);
        chk("bs_cursor", 32'(cur), 32'd17);
        chk("bs_cell17", 32'(chars[282]), 32'h20);
        chk("bs_cell16", 32'(chars[283]), 32'h78);
        chk("bs_update", 32'(upd), 32'd1);

        // fill whole buffer, last byte scrolls
        do_reset();
        for (int i = 0; i < N - 1; i++) send(8'(65 + i % 26));
        chk("fill_cursor299", 32'(cur), 32'd299);
        send(8'(65 + 299 % 26));
        chk("fill_ready_low", 32'(ready), 32'd0);
        @(negedge clk);
        chk("fill_ready_back", 32'(ready), 32'd1);
        chk("fill_cursor", 32'(cur), 32'd284);
        chk("fill_cell0", 32'(chars[299]), 32'h51);
        chk("fill_cell283", 32'(chars[16]), 32'h4E);
        chk("fill_cell284", 32'(chars[15]), 32'h20);
        chk("fill_cell299", 32'(chars[0]), 32'h20);

        // LF across the partial last row
        send(8'h0A);
        chk("lf_partial_cursor", 32'(cur), 32'd288);
        send(8'h0A);
        @(negedge clk);
        chk("lf_scroll_cursor", 32'(cur), 32'd288);
        chk("lf_scroll_cell0", 32'(chars[299]), 32'h47);

        // form feed with a byte held during the clear
        send(8'h0C);
        byt = 8'h51; dv = 1'b1;
        cnt = 0; all_upd = 1;
        while (!ready && cnt < 1000) begin
            all_upd &= upd;
            cnt++;
            @(negedge clk);
        end
        dv = 1'b0;
        chk("ff_busy_cycles", 32'(cnt), 32'd300);
        chk("ff_update_held", 32'(all_upd), 32'd1);
        chk("ff_cursor", 32'(cur), 32'd0);
        chk("ff_cell0", 32'(chars[299]), 32'h20);
        @(negedge clk);
        chk("ff_held_not_taken", 32'(cur), 32'd0);

        // reset during clear
        send(8'h5A);
        send(8'h0C);
        repeat (50) @(negedge clk);
        chk("midclr_busy", 32'(ready), 32'd0);
        do_reset();
        chk("midclr_ready", 32'(ready), 32'd1);
        chk("midclr_cursor", 32'(cur), 32'd0);
        chk("midclr_cell0", 32'(chars[299]), 32'h20);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
